// File: rtl/k007232_vol_mixer_if.sv
// Sample/volume/output bundle between the 007232 core side and the volume mixer.
interface k007232_vol_mixer_if;
    logic        CLKD4;
    logic [6:0]  ASD;
    logic [6:0]  BSD;
    logic        VOL_WR;
    logic [7:0]  DB;
    logic [11:0] SOUT;
    logic        SVALID;
    logic        OVR;

    modport master (output CLKD4, ASD, BSD, VOL_WR, DB, input SOUT, SVALID, OVR);
    modport slave  (input CLKD4, ASD, BSD, VOL_WR, DB, output SOUT, SVALID, OVR);
endinterface

// File: rtl/k007232_vol_mixer.sv
// Per-channel volume multiply and two-channel mix for the 007232 PCM outputs.
// Optional DC blocker in the output path: define K007232_MIX_DC_BLOCK_EN.
module k007232_vol_mixer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OUT_SHIFT   = 0
) (
    input logic                CLK,
    input logic                RES,
    k007232_vol_mixer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL0, MUL1, SUM} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clkd4_sync, volwr_sync;
    logic                   clkd4_prev, volwr_prev;
    logic                   clkd4_rise, clkd4_fall, volwr_rise;

    logic [7:0]         db_cap;
    logic [3:0]         vol_a, vol_b, vol_snap;
    logic               pend_a, pend_b, ovr;
    logic [6:0]         hold_a, hold_b;
    logic               chan_b, start_a, start_b;
    logic signed [7:0]  s_q;
    logic signed [10:0] part_q, prod_a, prod_b;
    logic signed [10:0] s_ext, mul_lo, mul_hi, prod_new;
    logic signed [11:0] sum, sum_out;
    logic [11:0]        sout_q;
    logic               svalid_q;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            clkd4_sync <= '0;
            volwr_sync <= '0;
            clkd4_prev <= 1'b0;
            volwr_prev <= 1'b0;
        end else begin
            clkd4_sync <= {clkd4_sync[SYNC_STAGES-2:0], bus.CLKD4};
            volwr_sync <= {volwr_sync[SYNC_STAGES-2:0], bus.VOL_WR};
            clkd4_prev <= clkd4_sync[SYNC_STAGES-1];
            volwr_prev <= volwr_sync[SYNC_STAGES-1];
        end
    end

    assign clkd4_rise = clkd4_sync[SYNC_STAGES-1] & ~clkd4_prev;
    assign clkd4_fall = ~clkd4_sync[SYNC_STAGES-1] & clkd4_prev;
    assign volwr_rise = volwr_sync[SYNC_STAGES-1] & ~volwr_prev;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            db_cap <= '0;
            vol_a  <= '0;
            vol_b  <= '0;
        end else begin
            if (!volwr_sync[SYNC_STAGES-1]) db_cap <= bus.DB;
            if (volwr_rise) begin
                vol_a <= db_cap[3:0];
                vol_b <= db_cap[7:4];
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start_a = 1'b0;
        start_b = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_a) begin
                    start_a = 1'b1;
                    state_d = MUL0;
                end else if (pend_b) begin
                    start_b = 1'b1;
                    state_d = MUL0;
                end
            end
            MUL0:    state_d = MUL1;
            MUL1:    state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 4-bit volume multiply split into two 2-bit partial products over MUL0/MUL1.
    assign s_ext    = {{3{s_q[7]}}, s_q};
    assign mul_lo   = s_ext * $signed({9'b0, vol_snap[1:0]});
    assign mul_hi   = s_ext * $signed({9'b0, vol_snap[3:2]});
    assign prod_new = part_q + (mul_hi <<< 2);
    assign sum      = {prod_a[10], prod_a} + {prod_b[10], prod_b};

`ifdef K007232_MIX_DC_BLOCK_EN
    logic signed [15:0] x_prev, y_prev, x_ext, y_new;
    logic signed [11:0] y_sat;

    assign x_ext = {{4{sum[11]}}, sum};
    assign y_new = x_ext - x_prev + y_prev - (y_prev >>> 6);

    always_comb begin
        y_sat = y_new[11:0];
        if (y_new > 16'sd2047)       y_sat = 12'sd2047;
        else if (y_new < -16'sd2048) y_sat = -12'sd2048;
    end

    assign sum_out = y_sat >>> OUT_SHIFT;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (state_q == SUM) begin
            x_prev <= x_ext;
            y_prev <= y_new;
        end
    end
`else
    assign sum_out = sum >>> OUT_SHIFT;
`endif

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            ovr      <= 1'b0;
            hold_a   <= '0;
            hold_b   <= '0;
            chan_b   <= 1'b0;
            vol_snap <= '0;
            s_q      <= '0;
            part_q   <= '0;
            prod_a   <= '0;
            prod_b   <= '0;
            sout_q   <= '0;
            svalid_q <= 1'b0;
        end else begin
            // A new event wins over the clear from a job starting in the same cycle.
            if (clkd4_rise) begin
                hold_a <= bus.ASD;
                pend_a <= 1'b1;
                if (pend_a && !start_a) ovr <= 1'b1;
            end else if (start_a) begin
                pend_a <= 1'b0;
            end
            if (clkd4_fall) begin
                hold_b <= bus.BSD;
                pend_b <= 1'b1;
                if (pend_b && !start_b) ovr <= 1'b1;
            end else if (start_b) begin
                pend_b <= 1'b0;
            end

            if (start_a || start_b) begin
                chan_b   <= start_b;
                vol_snap <= start_a ? vol_a : vol_b;
                s_q      <= $signed({1'b0, start_a ? hold_a : hold_b}) - 8'sd64;
            end
            if (state_q == MUL0) part_q <= mul_lo;
            if (state_q == MUL1) begin
                if (chan_b) prod_b <= prod_new;
                else        prod_a <= prod_new;
            end
            if (state_q == SUM) sout_q <= sum_out;
            svalid_q <= (state_q == SUM);
        end
    end

    assign bus.SOUT   = sout_q;
    assign bus.SVALID = svalid_q;
    assign bus.OVR    = ovr;
endmodule

// File: tb/tb_k007232_vol_mixer.sv
// Directed self-checking bench for k007232_vol_mixer (default build or K007232_MIX_DC_BLOCK_EN).
module tb_k007232_vol_mixer;
    localparam int unsigned S = 2;

    logic CLK = 1'b0;
    logic RES;
    int   errors = 0;
    int   checks = 0;
    int   run = 0;
    int   max_run = 0;
    int   nval = 0;
    int   last_sout = 0;

    k007232_vol_mixer_if bus ();

    k007232_vol_mixer #(.SYNC_STAGES(S), .OUT_SHIFT(0)) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] sout_s();
        return 32'($signed(bus.SOUT));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_vol(input logic [7:0] v);
        bus.DB     = v;
        bus.VOL_WR = 1'b0;
        repeat (4) tick();
        bus.VOL_WR = 1'b1;
        repeat (4) tick();
    endtask

    task automatic edge_chk(input string tag, input logic lvl, input int exp);
        bus.CLKD4 = lvl;
        repeat (S + 4) tick();
        chk({tag, "_early"}, 32'(bus.SVALID), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.SVALID), 32'd1);
        chk({tag, "_sout"}, sout_s(), exp);
        tick();
        chk({tag, "_pulse"}, 32'(bus.SVALID), 32'd0);
    endtask

    task automatic track();
        if (bus.SVALID) begin
            run++;
            nval++;
            last_sout = int'($signed(bus.SOUT));
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
    endtask

    initial begin
        RES        = 1'b1;
        bus.CLKD4  = 1'b0;
        bus.ASD    = 7'h40;
        bus.BSD    = 7'h40;
        bus.VOL_WR = 1'b1;
        bus.DB     = 8'h00;
        repeat (3) tick();
        chk("rst_sout", sout_s(), 32'd0);
        chk("rst_svalid", 32'(bus.SVALID), 32'd0);
        chk("rst_ovr", 32'(bus.OVR), 32'd0);
        RES = 1'b0;
        repeat (6) tick();

`ifdef K007232_MIX_DC_BLOCK_EN
        write_vol(8'h0F);
        bus.ASD = 7'h50;
        bus.BSD = 7'h40;
        edge_chk("dc1", 1'b1, 240);
        edge_chk("dc2", 1'b0, 237);
        edge_chk("dc3", 1'b1, 234);
`else
        // A=15, B=3; A sample +16, B sample zero
        write_vol(8'h3F);
        bus.ASD = 7'h50;
        bus.BSD = 7'h40;
        edge_chk("t1_rise", 1'b1, 240);
        edge_chk("t1_fall", 1'b0, 240);

        // Full-scale extremes at max volume
        write_vol(8'hFF);
        bus.ASD = 7'h00;
        bus.BSD = 7'h7F;
        edge_chk("t2_rise", 1'b1, -960);
        edge_chk("t2_fall", 1'b0, -15);

        // Volume 0 mid-stream
        write_vol(8'h00);
        edge_chk("t3_rise", 1'b1, 945);
        edge_chk("t3_fall", 1'b0, 0);
        chk("t3_ovr", 32'(bus.OVR), 32'd0);

        // Burst of 1-CLK half-periods with A=B=1
        write_vol(8'h11);
        bus.ASD = 7'h60;
        bus.BSD = 7'h30;
        run = 0;
        max_run = 0;
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            bus.CLKD4 = ~bus.CLKD4;
            tick();
            track();
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            track();
        end
        chk("burst_ovr", 32'(bus.OVR), 32'd1);
        chk("burst_seen", 32'(nval > 0), 32'd1);
        chk("burst_pulse_len", 32'(max_run), 32'd1);
        chk("burst_last_sout", 32'(last_sout), 32'd16);

        // Reset while the A job sits in MUL1
        bus.CLKD4 = 1'b1;
        repeat (S + 3) tick();
        RES = 1'b1;
        #1;
        chk("midrst_sout", sout_s(), 32'd0);
        chk("midrst_svalid", 32'(bus.SVALID), 32'd0);
        chk("midrst_ovr", 32'(bus.OVR), 32'd0);
        bus.CLKD4 = 1'b0;
        bus.DB    = 8'h00;
        repeat (2) tick();
        RES = 1'b0;
        nval = 0;
        run = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            track();
        end
        chk("postrst_quiet", 32'(nval), 32'd0);
        write_vol(8'h0F);
        bus.ASD = 7'h50;
        edge_chk("postrst_rise", 1'b1, 240);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/k007232_vol_mixer.md
Name: k007232_vol_mixer

Overview:
- Downstream stage of the 007232 PCM core.
- Consumes the two 7-bit unsigned channel sample buses (ASD, BSD) and the CLK/4 channel-phase signal that the core latches them with.
- Applies a per-channel 4-bit volume, written through the core's external-volume strobe (SOEV-style, active-low), and sums both channels.
- Produces one signed mono sample stream with a valid pulse, for the board DAC or mixer model.

Parameters:
- SYNC_STAGES, 2: flip-flop depth for synchronising CLKD4 and VOL_WR into CLK; legal range 2..3.
- OUT_SHIFT, 0: arithmetic right shift applied to the 12-bit sum before output; legal range 0..4.

Ports:
- CLK  in  1  block clock.
- RES  in  1  asynchronous reset, active high.
- CLKD4  in  1  channel phase from the 007232. Rising edge: ASD updated. Falling edge: BSD updated.
- ASD  in  7  channel A sample, offset binary (0x40 = zero).
- BSD  in  7  channel B sample, offset binary.
- VOL_WR  in  1  volume write strobe, active low (SOEV).
- DB  in  8  CPU data bus. DB[3:0] = volume A, DB[7:4] = volume B.
- SOUT  out  12  signed mixed sample.
- SVALID  out  1  one-CLK pulse when SOUT updates.
- OVR  out  1  sticky overrun flag.

Behaviour:
- Reset (RES high, asynchronous): SOUT=0, SVALID=0, OVR=0, volume A=B=0, both stored products=0, pending flags clear, FSM=IDLE, sync chains=0.
- CLKD4 and VOL_WR each pass through SYNC_STAGES flops, then a registered edge detector.
- Sync chains reset to 0, so a CLKD4 already high at reset release produces one rising-edge event.
- Volume register:
  - DB is captured every CLK while synced VOL_WR is low.
  - On synced VOL_WR rising edge, the last capture commits to both volumes.
  - A multiply already in flight uses the volume snapshotted at its start.
- Sample events:
  - A CLKD4 rising edge sets pend_A and captures ASD into holdA.
  - A CLKD4 falling edge sets pend_B and captures BSD into holdB.
  - Capture happens in the edge-detect cycle.
- Overrun: if an event arrives while that channel's pend flag is still set, the hold register is overwritten with the newer sample and OVR sets. OVR clears only on reset.
- FSM states: IDLE, MUL0, MUL1, SUM.
  - IDLE: if pend_A, start channel A (A has priority when both are pending); else if pend_B, start B. On start: clear that pend flag, snapshot volume, form s = hold - 64 (8-bit signed, range -64..63). Go to MUL0.
  - MUL0: partial product = s * vol[1:0]. Go to MUL1.
  - MUL1: add (s * vol[3:2]) << 2; product is 11-bit signed, range -960..945. Store into prodA or prodB. Go to SUM.
  - SUM: sum = prodA + prodB (12-bit signed, cannot overflow). SOUT <= sum >>> OUT_SHIFT. SVALID=1 for this one CLK. Go to IDLE.
- SOUT and SVALID are registered outputs.
- Latency: with FSM idle, SVALID asserts SYNC_STAGES+4 CLKs after the first CLK edge that samples the new CLKD4 level.
- Throughput requirement: each CLKD4 half-period must be at least 4 CLK. Shorter half-periods are legal but may raise OVR.
- Volume 0 yields product 0 regardless of sample. Sample 0x40 yields 0 regardless of volume.
- Reset mid-multiply: everything returns to reset values immediately, and no SVALID is emitted.

Optional Feature:
- Macro K007232_MIX_DC_BLOCK_EN.
- Defined:
  - Insert a DC blocker in SUM: y = x - x_prev + y_prev - (y_prev >>> 6), where x is the 12-bit sum.
  - x_prev and y_prev are 16-bit signed registers, reset to 0, updated only in SUM.
  - SOUT = saturate(y to 12-bit signed) >>> OUT_SHIFT.
  - Latency is unchanged.
- Undefined: the sum goes straight to the shift as described above, with no extra registers.

Test Plan:
- Reset, write DB=0x3F (A=15, B=3), ASD=0x50, BSD=0x40, toggle CLKD4 every 8 CLK -> after the rising edge, SOUT=240 at exactly SYNC_STAGES+4 CLKs; after the falling edge, SOUT=240 again.
- Volumes A=B=15, ASD=0x00, BSD=0x7F -> after both edges, SOUT=-15 (0xFF1); with A alone processed, SOUT=-960.
- Write DB=0x00 mid-stream -> next products are 0, SOUT=0 after both channels update; OVR stays 0.
- Toggle CLKD4 every 1 CLK for 10 edges -> OVR=1, last SOUT reflects the newest held samples, no SVALID pulse longer than 1 CLK.
- Assert RES during MUL1 -> SOUT=0, SVALID=0, OVR=0 immediately; no SVALID after release until a new CLKD4 edge.
- With K007232_MIX_DC_BLOCK_EN: constant sum 240 -> first SOUT=240, then monotonic decay toward 0 (second output 237).
